unidad_control_pila: RTL

- Parametrised successor of the microcontroller control unit; decodes the 6-bit Opcode from microc and drives datapath selects, write enables and ALUOp.
- Adds CALL/RET with an internal return-address stack of configurable depth and PC width.
- Adds a HALT state. Register writes and PC updates are gated by a run/halt FSM.

---
 rtl/uc_pkg.sv | 29 ++
 rtl/pila_retorno.sv | 60 ++++++
 rtl/unidad_control_pila.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the stack-capable control unit.
//   - Opcode constants and opcode-class prefixes.
//   - Run/halt FSM state encoding.
//   - ALUOp width default.
// Optional feature: UC_STACK_FAULT_EN adds the FAULT state.
package uc_pkg;

  localparam int ALUOP_W_DEF = 3;

  // Opcode[5:4] class prefixes.
  localparam logic [1:0] CLS_ALU = 2'b00;  // 00_0aaa, bit 3 must also be 0
  localparam logic [1:0] CLS_LDI = 2'b01;  // 01_xxxx

  localparam logic [5:0] OP_J    = 6'b10_0000;
  localparam logic [5:0] OP_JZ   = 6'b10_0001;
  localparam logic [5:0] OP_JNZ  = 6'b10_0010;
  localparam logic [5:0] OP_CALL = 6'b10_0011;
  localparam logic [5:0] OP_RET  = 6'b10_0100;
  localparam logic [5:0] OP_HALT = 6'b11_1111;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1
`ifdef UC_STACK_FAULT_EN
    , ST_FAULT = 2'd2
`endif
  } uc_state_e;

endpackage

// File: rtl/pila_retorno.sv
// pila_retorno: return-address LIFO for CALL/RET.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (clears the pointer only)
//   push, wdata    store wdata on top; when full the top entry is overwritten
//   pop            drop the top entry; ignored when empty
//   rdata          top entry (mem[sp-1]), 0 when empty
//   count          occupancy sp, 0..DEPTH
module pila_retorno
  import uc_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PC_W-1:0]          wdata,
  output logic [PC_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] mem [DEPTH];
  logic [CW-1:0]   sp;
  logic            full;
  logic            empty;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign full   = (sp == CW'(DEPTH));
  assign empty  = (sp == '0);
  // A full stack keeps its pointer and rewrites the top slot.
  assign wr_idx = full ? AW'(DEPTH - 1) : sp[AW-1:0];
  // DEPTH is a power of two, so sp==DEPTH wraps to index DEPTH-1 here.
  assign rd_idx = sp[AW-1:0] - AW'(1);
  assign rdata  = empty ? '0 : mem[rd_idx];
  assign count  = sp;

  // NOTE: the storage array has no reset; its contents are don't-care until
  // pushed, and leaving it unreset lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + CW'(1);
    end else if (pop && !empty) begin
      sp <= sp - CW'(1);
    end
  end

endmodule

// File: rtl/unidad_control_pila.sv
// unidad_control_pila: microcontroller control unit with CALL/RET and HALT.
// Decodes Opcode/zero combinationally into datapath selects and enables;
// a run/halt FSM gates register writes, PC loads and stack traffic.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   Opcode, zero       instruction opcode and registered zero flag
//   pc_plus1           PC+1, pushed as the return address on CALL
//   s_inc, s_inm       next-PC and write-data selects
//   s_ret              next PC is ret_addr (takes priority over s_inc)
//   we, wez, ALUOp     register/zero-flag write enables, ALU operation
//   pc_en              PC load enable
//   ret_addr, depth_o  top of return stack, stack occupancy
//   halted             FSM is in HALT (or FAULT)
// Optional feature: define UC_STACK_FAULT_EN to trap stack overflow and
// underflow into a FAULT state instead of overwriting / clamping.
module unidad_control_pila
  import uc_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int DEPTH   = 8,
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              Opcode,
  input  logic                    zero,
  input  logic [PC_W-1:0]         pc_plus1,
  output logic                    s_inc,
  output logic                    s_inm,
  output logic                    s_ret,
  output logic                    we,
  output logic                    wez,
  output logic [ALUOP_W-1:0]      ALUOp,
  output logic                    pc_en,
  output logic [PC_W-1:0]         ret_addr,
  output logic                    halted,
  output logic [$clog2(DEPTH):0]  depth_o
);

  uc_state_e state;
  logic      run;
  logic      we_d, wez_d;
  logic      push_req, pop_req, halt_req;
  logic      fault_now;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the decode leaves a value held and no latch is inferred.
  always_comb begin
    s_inc    = 1'b1;
    s_inm    = 1'b0;
    s_ret    = 1'b0;
    we_d     = 1'b0;
    wez_d    = 1'b0;
    ALUOp    = '0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    halt_req = 1'b0;
    if (Opcode[5:4] == CLS_ALU && !Opcode[3]) begin
      ALUOp = ALUOP_W'(Opcode[2:0]);
      we_d  = 1'b1;
      wez_d = 1'b1;
    end else if (Opcode[5:4] == CLS_LDI) begin
      s_inm = 1'b1;
      we_d  = 1'b1;
    end else begin
      case (Opcode)
        OP_J:    s_inc = 1'b0;
        OP_JZ:   s_inc = ~zero;
        OP_JNZ:  s_inc = zero;
        OP_CALL: begin
          s_inc    = 1'b0;
          push_req = 1'b1;
        end
        OP_RET: begin
          s_ret   = 1'b1;
          pop_req = 1'b1;
        end
        OP_HALT: halt_req = 1'b1;
        default: ;
      endcase
    end
  end

  assign run = (state == ST_RUN);

`ifdef UC_STACK_FAULT_EN
  // Overflow/underflow stops on the offending instruction: PC held, stack
  // untouched, FAULT entered on the same edge.
  assign fault_now = run && ((push_req && depth_o == ($clog2(DEPTH)+1)'(DEPTH)) ||
                             (pop_req  && depth_o == '0));
`else
  assign fault_now = 1'b0;
`endif

  assign pc_en = run && !fault_now;
  assign we    = run && we_d;
  assign wez   = run && wez_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
`ifdef UC_STACK_FAULT_EN
          if (fault_now) begin
            state  <= ST_FAULT;
            halted <= 1'b1;
          end else
`endif
          if (halt_req) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        default: ;  // HALT and FAULT are left only through reset
      endcase
    end
  end

  pila_retorno #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_pila (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_req && pc_en),
    .pop   (pop_req && pc_en),
    .wdata (pc_plus1),
    .rdata (ret_addr),
    .count (depth_o)
  );

endmodule
